// File: rtl/apb_master_pkg.sv
// ============================================================================
// Module      : apb_master_pkg
// Description : Shared types and I2C core register map for the APB requester.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned ADDR_TX_FIFO = 0;
  localparam int unsigned ADDR_RX_FIFO = 4;
  localparam int unsigned ADDR_CONFIG  = 8;
  localparam int unsigned ADDR_TIMEOUT = 12;
  localparam int unsigned ADDR_CUR_TX  = 16;

endpackage

`default_nettype wire

// File: rtl/apb_master_wdog.sv
// ============================================================================
// Module      : apb_master_wdog
// Description : pready watchdog; expired fires on the TIMEOUT-th stalled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT != 0) begin : g_wdog_on
      localparam int unsigned c_cnt_w = $clog2(TIMEOUT + 1);
      localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 1);

      logic [c_cnt_w-1:0] r_cnt;

      // The transfer ends when the count reaches TIMEOUT, so it cannot wrap.
      always_ff @(posedge pclk) begin
        if (!presetn || clear) begin
          r_cnt <= '0;
        end else if (enable) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign expired = enable && (r_cnt == c_limit);
    end else begin : g_wdog_off
      logic w_unused;
      assign w_unused = &{1'b0, pclk, presetn, clear, enable};
      assign expired  = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_master_requester.sv
// ============================================================================
// Module      : apb_master_requester
// Description : APB3 requester turning valid/ready commands into APB transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_requester
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_done;
  logic   w_expired;
  logic   w_wdog_en;
  logic   w_wdog_clr;

  // Kept outside the FSM block so the watchdog output does not loop back into it.
  assign w_wdog_en  = (r_state == ACCESS) && !pready;
  assign w_wdog_clr = (r_state == RESP) && rsp_ready;
  assign busy       = (r_state != IDLE);

  apb_master_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .pclk    (pclk),
    .presetn (presetn),
    .clear   (w_wdog_clr),
    .enable  (w_wdog_en),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    pselx       = 1'b0;
    penable     = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = presetn;
        w_accept  = cmd_valid && presetn;
        if (w_accept) begin
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        pselx       = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        pselx   = 1'b1;
        penable = 1'b1;
        if (pready || w_expired) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state     <= IDLE;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      // pready wins over the watchdog when both land in the same cycle.
      if (w_done) begin
        if (pready) begin
          rsp_rdata   <= pwrite ? '0 : prdata;
          rsp_slverr  <= pslverr;
          rsp_timeout <= 1'b0;
        end else begin
          rsp_rdata   <= '0;
          rsp_slverr  <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_master_requester.sv
// ============================================================================
// Module      : tb_apb_master_requester
// Description : Directed bench for apb_master_requester (TIMEOUT=4 and TIMEOUT=0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_requester;
  import apb_master_pkg::*;

  logic        pclk = 1'b0;
  logic        presetn, cmd_valid, cmd_write, rsp_ready, pready, pslverr;
  logic [31:0] cmd_addr, cmd_wdata, prdata;

  logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, pselx, penable, pwrite, busy;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic        z_cmd_ready, z_rsp_valid, z_rsp_slverr, z_rsp_timeout, z_pselx, z_penable, z_pwrite, z_busy;
  logic [31:0] z_rsp_rdata, z_paddr, z_pwdata;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .pselx(pselx),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  apb_master_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid), .cmd_ready(z_cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_slverr(z_rsp_slverr), .rsp_timeout(z_rsp_timeout), .pselx(z_pselx),
    .penable(z_penable), .pwrite(z_pwrite), .paddr(z_paddr), .pwdata(z_pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(z_busy)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    presetn = 1'b1;
  endtask

  // Offer one command in IDLE; returns one step into the SETUP cycle.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hFFFF;
    rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
    tick(); tick(); #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, pselx, penable, pwrite, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, pselx, penable, pwrite, busy}, 8'h00);
    end
    checks++;
    if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected %h", {paddr, pwdata, rsp_rdata}, 96'h0);
    end
    checks++;
    if ({z_cmd_ready, z_rsp_valid, z_rsp_slverr, z_rsp_timeout, z_pselx, z_penable, z_pwrite, z_busy,
         z_paddr, z_pwdata, z_rsp_rdata} !== 104'h0) begin
      errors++;
      $display("FAIL reset_dut0: got %h expected 0",
               {z_cmd_ready, z_rsp_valid, z_rsp_slverr, z_rsp_timeout, z_pselx, z_penable, z_pwrite, z_busy,
                z_paddr, z_pwdata, z_rsp_rdata});
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    presetn = 1'b1; #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", {cmd_ready, busy}, 2'b10);
    end
  endtask

  task automatic test_write_config();
    do_reset();
    pready = 1'b1; pslverr = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'(ADDR_CONFIG); cmd_wdata = 32'h0000_1A2B; #1;
    checks++;
    if ({cmd_ready, pselx, penable} !== 3'b100) begin
      errors++;
      $display("FAIL wr_idle: got %b expected %b", {cmd_ready, pselx, penable}, 3'b100);
    end
    tick();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; #1;
    checks++;
    if ({pselx, penable, pwrite, busy, cmd_ready} !== 5'b10110 || paddr !== 32'h8 || pwdata !== 32'h1A2B) begin
      errors++;
      $display("FAIL wr_setup: got ctl=%b addr=%h data=%h expected ctl=10110 addr=8 data=1a2b",
               {pselx, penable, pwrite, busy, cmd_ready}, paddr, pwdata);
    end
    tick(); #1;
    checks++;
    if ({pselx, penable, rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL wr_access: got %b expected %b", {pselx, penable, rsp_valid}, 3'b110);
    end
    tick(); #1;
    checks++;
    if ({pselx, penable, rsp_valid, rsp_slverr, rsp_timeout} !== 5'b00100 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_resp: got ctl=%b rdata=%h expected ctl=00100 rdata=0",
               {pselx, penable, rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; #1;
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL wr_done: got %b expected %b", {rsp_valid, busy, cmd_ready}, 3'b001);
    end
  endtask

  task automatic test_read_wait();
    int n_access;
    do_reset();
    prdata = 32'h0000_BEEF; pready = 1'b0;
    issue(1'b0, 32'(ADDR_RX_FIFO), 32'hDEAD); #1;
    checks++;
    if ({pselx, penable} !== 2'b10 || paddr !== 32'h4) begin
      errors++;
      $display("FAIL rd_setup: got ctl=%b addr=%h expected ctl=10 addr=4", {pselx, penable}, paddr);
    end
    n_access = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pready = (i == 3);
      #1;
      if (pselx && penable && !rsp_valid && paddr == 32'h4 && !pwrite) n_access++;
    end
    checks++;
    if (n_access !== 4) begin
      errors++;
      $display("FAIL rd_access_len: got %0d expected %0d", n_access, 4);
    end
    tick(); pready = 1'b0; #1;
    checks++;
    if ({rsp_valid, pselx, penable, rsp_slverr, rsp_timeout} !== 5'b10000 || rsp_rdata !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL rd_resp: got ctl=%b rdata=%h expected ctl=10000 rdata=0000beef",
               {rsp_valid, pselx, penable, rsp_slverr, rsp_timeout}, rsp_rdata);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_slverr();
    do_reset();
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE;
    issue(1'b1, 32'(ADDR_TX_FIFO), 32'h55);
    tick(); tick(); #1;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL slverr_resp: got ctl=%b rdata=%h expected ctl=110 rdata=0",
               {rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata);
    end
    pslverr = 1'b0; rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n_access, z_bad, hold_bad;
    do_reset();
    pready = 1'b0;
    issue(1'b1, 32'(ADDR_TIMEOUT), 32'h7);
    n_access = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      if (pselx && penable && !rsp_valid) n_access++;
    end
    checks++;
    if (n_access !== 4) begin
      errors++;
      $display("FAIL to_access_len: got %0d expected %0d", n_access, 4);
    end
    tick(); #1;
    checks++;
    if ({rsp_valid, rsp_timeout, rsp_slverr, pselx, penable} !== 5'b11100 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_resp: got ctl=%b rdata=%h expected ctl=11100 rdata=0",
               {rsp_valid, rsp_timeout, rsp_slverr, pselx, penable}, rsp_rdata);
    end
    z_bad = 0; hold_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!(z_pselx && z_penable && !z_rsp_valid && z_busy)) z_bad++;
      if (!(rsp_valid && rsp_timeout && rsp_slverr)) hold_bad++;
    end
    checks++;
    if (z_bad !== 0) begin
      errors++;
      $display("FAIL to_disabled_hold: got %0d bad cycles expected %0d", z_bad, 0);
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL to_resp_hold: got %0d bad cycles expected %0d", hold_bad, 0);
    end
    pready = 1'b1; tick(); pready = 1'b0; #1;
    checks++;
    if ({z_rsp_valid, z_rsp_timeout, z_rsp_slverr, z_pselx} !== 4'b1000) begin
      errors++;
      $display("FAIL to_disabled_done: got %b expected %b",
               {z_rsp_valid, z_rsp_timeout, z_rsp_slverr, z_pselx}, 4'b1000);
    end
  endtask

  task automatic test_back_to_back();
    int stable_bad;
    do_reset();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234;
    issue(1'b1, 32'h10, 32'h11);
    tick(); tick();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_wdata = 32'h99;
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      if ({rsp_valid, rsp_slverr, rsp_timeout, cmd_ready, pselx} !== 5'b10000 ||
          rsp_rdata !== 32'h0 || paddr !== 32'h10) stable_bad++;
    end
    checks++;
    if (stable_bad !== 0) begin
      errors++;
      $display("FAIL b2b_stall: got %0d unstable cycles expected %0d", stable_bad, 0);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; #1;
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_idle: got %b expected %b", {rsp_valid, busy, cmd_ready}, 3'b001);
    end
    tick(); cmd_valid = 1'b0; #1;
    checks++;
    if ({pselx, penable, pwrite} !== 3'b100 || paddr !== 32'h4) begin
      errors++;
      $display("FAIL b2b_second_setup: got ctl=%b addr=%h expected ctl=100 addr=4", {pselx, penable, pwrite}, paddr);
    end
    tick(); tick(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234) begin
      errors++;
      $display("FAIL b2b_second_resp: got valid=%b rdata=%h expected valid=1 rdata=1234", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pready = 1'b0;
    issue(1'b0, 32'(ADDR_CONFIG), 32'h0);
    tick(); tick();
    presetn = 1'b0;
    tick(); #1;
    checks++;
    if ({cmd_ready, rsp_valid, pselx, penable, busy, rsp_slverr, rsp_timeout} !== 7'h00 || paddr !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got ctl=%b addr=%h expected ctl=0000000 addr=0",
               {cmd_ready, rsp_valid, pselx, penable, busy, rsp_slverr, rsp_timeout}, paddr);
    end
    presetn = 1'b1; pready = 1'b1; prdata = 32'h77;
    tick(); #1;
    checks++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset_release: got %b expected %b", {cmd_ready, rsp_valid, busy}, 3'b100);
    end
    issue(1'b0, 32'h4, 32'h0);
    tick(); tick(); #1;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h77) begin
      errors++;
      $display("FAIL mid_reset_next: got ctl=%b rdata=%h expected ctl=100 rdata=77",
               {rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_config();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
